// File: rtl/axis_chk_pkg.sv
// Shared types and helpers for the AXI4-Stream counter-pattern checker.
// Holds the FSM state type, LFSR constants and the saturating-increment helper.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Callers widen to 64 bits and pass their own all-ones ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v >= max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/axis_chk_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that free-runs every cycle.
// Exposes both the current register value and the value it will take next.
module axis_chk_lfsr
    import axis_chk_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] lfsr_o,
    output logic [15:0] lfsr_next_o
);

    logic [15:0] lfsr_q;

    assign lfsr_next_o = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    assign lfsr_o      = lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next_o;
        end
    end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink that checks an incrementing-counter stream with TLAST framing.
// Counts beats, packets, data and framing errors; optional LFSR-gated TREADY.
module axis_stream_checker
    import axis_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN_W  = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  cfg_enable,
    input  logic                  cfg_clear,
    input  logic                  cfg_throttle,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [PKT_LEN_W-1:0]  cfg_pkt_len,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      data_err_cnt,
    output logic [CNT_W-1:0]      last_err_cnt,
    output logic                  err_flag,
    output logic                  busy
);

    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [63:0] POS_MAX = (64'd1 << PKT_LEN_W) - 64'd1;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;
    logic [PKT_LEN_W-1:0]    pos_q, pos_d;
    logic                    tready_q, tready_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [CNT_W-1:0]        pkt_q, pkt_d;
    logic [CNT_W-1:0]        derr_q, derr_d;
    logic [CNT_W-1:0]        lerr_q, lerr_d;
    logic                    err_q, err_d;

    logic [15:0]             lfsr_unused;
    logic [15:0]             lfsr_next;
    logic                    hs;
    logic                    len_chk;
    logic                    exp_last;
    logic                    data_bad;
    logic                    last_bad;

    axis_chk_lfsr u_lfsr (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .lfsr_o      (lfsr_unused),
        .lfsr_next_o (lfsr_next)
    );

    assign hs       = s_axis_tvalid & tready_q;
    assign len_chk  = (cfg_pkt_len != '0);
    assign exp_last = len_chk & (pos_q == (cfg_pkt_len - PKT_LEN_W'(1)));
    assign data_bad = hs & (s_axis_tdata != exp_q);
    assign last_bad = hs & len_chk & (s_axis_tlast != exp_last);

    // A session that stops mid-packet drains until the closing TLAST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_enable) state_d = RUN;
            RUN:     if (!cfg_enable) state_d = (pos_q == '0) ? IDLE : DRAIN;
            DRAIN:   if (hs && s_axis_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exp_d  = exp_q;
        pos_d  = pos_q;
        beat_d = beat_q;
        pkt_d  = pkt_q;
        derr_d = derr_q;
        lerr_d = lerr_q;
        err_d  = err_q;

        if (state_q == IDLE && cfg_enable) begin
            exp_d = cfg_seed;
            pos_d = '0;
        end

        if (hs) begin
            beat_d = CNT_W'(sat_inc(64'(beat_q), CNT_MAX));
            exp_d  = exp_q + DATA_WIDTH'(1);
            if (data_bad) derr_d = CNT_W'(sat_inc(64'(derr_q), CNT_MAX));
            if (last_bad) lerr_d = CNT_W'(sat_inc(64'(lerr_q), CNT_MAX));
            if (s_axis_tlast) begin
                pkt_d = CNT_W'(sat_inc(64'(pkt_q), CNT_MAX));
                pos_d = '0;
            end else begin
                pos_d = PKT_LEN_W'(sat_inc(64'(pos_q), POS_MAX));
            end
            err_d = err_q | data_bad | last_bad;
        end

        // Clear wins over a beat landing in the same cycle.
        if (cfg_clear) begin
            exp_d  = cfg_seed;
            pos_d  = '0;
            beat_d = '0;
            pkt_d  = '0;
            derr_d = '0;
            lerr_d = '0;
            err_d  = 1'b0;
        end
    end

    assign tready_d = (state_d != IDLE) & ~cfg_clear & (~cfg_throttle | lfsr_next[0]);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            pos_q    <= '0;
            tready_q <= 1'b0;
            beat_q   <= '0;
            pkt_q    <= '0;
            derr_q   <= '0;
            lerr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            pos_q    <= pos_d;
            tready_q <= tready_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
            derr_q   <= derr_d;
            lerr_q   <= lerr_d;
            err_q    <= err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign beat_cnt      = beat_q;
    assign pkt_cnt       = pkt_q;
    assign data_err_cnt  = derr_q;
    assign last_err_cnt  = lerr_q;
    assign err_flag      = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker: directed vector table, hand-written corner
// sequences and randomized sessions scored against a packet-level model.
module tb_axis_stream_checker;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          cfg_enable = 1'b0;
    logic          cfg_clear = 1'b0;
    logic          cfg_throttle = 1'b0;
    logic [DW-1:0] cfg_seed = '0;
    logic [LW-1:0] cfg_pkt_len = '0;
    logic [CW-1:0] beat_cnt, pkt_cnt, data_err_cnt, last_err_cnt;
    logic          err_flag, busy;

    always #5 ACLK = ~ACLK;

    axis_stream_checker #(.DATA_WIDTH(DW), .PKT_LEN_W(LW), .CNT_W(CW)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .cfg_enable    (cfg_enable),
        .cfg_clear     (cfg_clear),
        .cfg_throttle  (cfg_throttle),
        .cfg_seed      (cfg_seed),
        .cfg_pkt_len   (cfg_pkt_len),
        .beat_cnt      (beat_cnt),
        .pkt_cnt       (pkt_cnt),
        .data_err_cnt  (data_err_cnt),
        .last_err_cnt  (last_err_cnt),
        .err_flag      (err_flag),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    // Packet-level reference: what a correct checker must have counted so far.
    logic [31:0] m_exp;
    int          m_pos, m_len, m_beat, m_pkt, m_derr, m_lerr;

    typedef struct {
        logic [31:0] seed;
        logic [15:0] len;
        int          nb;
        int          bad_idx;
        logic [31:0] bad_val;
        logic [15:0] last_mask;
        int          e_beat, e_pkt, e_derr, e_lerr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_start(input logic [31:0] seed, input int len);
        m_exp = seed; m_pos = 0; m_len = len;
        m_beat = 0; m_pkt = 0; m_derr = 0; m_lerr = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input logic l);
        m_beat++;
        if (d != m_exp) m_derr++;
        m_exp = m_exp + 32'd1;
        if (m_len != 0 && l != (m_pos == m_len - 1)) m_lerr++;
        if (l) begin
            m_pkt++;
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [31:0] d, input logic l, output int stalls);
        int n;
        n = 0;
        stalls = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge ACLK);
            stalls++;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=tready_low required=tready_high");
        end else begin
            @(negedge ACLK);
        end
    endtask

    task automatic start_session(input logic [31:0] seed, input logic [15:0] len, input logic thr);
        cfg_seed     = seed;
        cfg_pkt_len  = len;
        cfg_throttle = thr;
        cfg_clear    = 1'b1;
        @(negedge ACLK);
        cfg_clear    = 1'b0;
        cfg_enable   = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic end_session();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_enable    = 1'b0;
        repeat (3) @(negedge ACLK);
    endtask

    task automatic check_stats(input string nm, input int b, input int p, input int de, input int le);
        chk({nm, "_beat"},     beat_cnt, b);
        chk({nm, "_pkt"},      pkt_cnt, p);
        chk({nm, "_data_err"}, data_err_cnt, de);
        chk({nm, "_last_err"}, last_err_cnt, le);
        chk({nm, "_err_flag"}, err_flag, (de != 0 || le != 0));
        chk({nm, "_busy"},     busy, 0);
        chk({nm, "_tready"},   s_axis_tready, 0);
    endtask

    task automatic rand_session(input string nm, input logic [31:0] seed, input int len, input int nb,
                                input logic thr, input int gap_pct, input int err_pct,
                                output int stalls_total);
        logic [31:0] d;
        logic        l;
        int          st;
        stalls_total = 0;
        model_start(seed, len);
        start_session(seed, 16'(len), thr);
        for (int k = 0; k < nb; k++) begin
            if ($urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge ACLK);
            end
            d = m_exp;
            if ($urandom_range(99) < err_pct) d = d ^ (32'h1 << $urandom_range(31));
            l = (len != 0) ? (m_pos == len - 1) : ($urandom_range(3) == 0);
            if ($urandom_range(99) < err_pct) l = ~l;
            if (k == nb - 1) l = 1'b1;
            send_beat(d, l, st);
            stalls_total += st;
            model_beat(d, l);
        end
        end_session();
        check_stats(nm, m_beat, m_pkt, m_derr, m_lerr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, total;
        logic [31:0] d;

        //            seed          len    nb bad bad_val       mask    beat pkt derr lerr
        vecs[0] = '{32'd1,        16'd4, 8, 0, 32'h0,       16'h0088, 8, 2, 0, 0};
        vecs[1] = '{32'd1,        16'd4, 8, 3, 32'hDEAD,    16'h0088, 8, 2, 1, 0};
        vecs[2] = '{32'd1,        16'd4, 5, 0, 32'h0,       16'h0010, 5, 1, 0, 2};
        vecs[3] = '{32'hFFFFFFFE, 16'd0, 4, 0, 32'h0,       16'h000A, 4, 2, 0, 0};
        vecs[4] = '{32'd50,       16'd1, 3, 0, 32'h0,       16'h0005, 3, 2, 0, 2};
        vecs[5] = '{32'd7,        16'd3, 6, 6, 32'h0,       16'h0024, 6, 2, 1, 0};

        repeat (3) @(negedge ACLK);
        chk("reset_beat",     beat_cnt, 0);
        chk("reset_pkt",      pkt_cnt, 0);
        chk("reset_err_flag", err_flag, 0);
        chk("reset_busy",     busy, 0);
        chk("reset_tready",   s_axis_tready, 0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("idle_tready", s_axis_tready, 0);

        for (int i = 0; i < 6; i++) begin
            start_session(vecs[i].seed, vecs[i].len, 1'b0);
            total = 0;
            for (int k = 1; k <= vecs[i].nb; k++) begin
                d = vecs[i].seed + 32'(k - 1);
                if (k == vecs[i].bad_idx) d = vecs[i].bad_val;
                send_beat(d, vecs[i].last_mask[k-1], st);
                total += st;
            end
            end_session();
            chk($sformatf("v%0d_stalls", i), total, 0);
            check_stats($sformatf("v%0d", i), vecs[i].e_beat, vecs[i].e_pkt, vecs[i].e_derr, vecs[i].e_lerr);
        end

        // Drain: enable drops mid-packet, the rest of the packet is still taken.
        start_session(32'd1, 16'd4, 1'b0);
        send_beat(32'd1, 1'b0, st);
        send_beat(32'd2, 1'b0, st);
        cfg_enable = 1'b0;
        send_beat(32'd3, 1'b0, st);
        chk("drain_busy_mid", busy, 1);
        send_beat(32'd4, 1'b1, st);
        s_axis_tdata = 32'd5;
        s_axis_tlast = 1'b0;
        repeat (4) @(negedge ACLK);
        chk("drain_beat",   beat_cnt, 4);
        chk("drain_pkt",    pkt_cnt, 1);
        chk("drain_busy",   busy, 0);
        chk("drain_tready", s_axis_tready, 0);
        chk("drain_errs",   data_err_cnt + last_err_cnt, 0);
        s_axis_tvalid = 1'b0;

        // Clear landing on a handshake cycle.
        start_session(32'd10, 16'd4, 1'b0);
        send_beat(32'd10, 1'b0, st);
        send_beat(32'd99, 1'b0, st);
        chk("clr_pre_err_flag", err_flag, 1);
        chk("clr_pre_beat", beat_cnt, 2);
        s_axis_tdata  = 32'd12;
        s_axis_tvalid = 1'b1;
        cfg_clear     = 1'b1;
        @(negedge ACLK);
        cfg_clear     = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("clr_beat",     beat_cnt, 0);
        chk("clr_data_err", data_err_cnt, 0);
        chk("clr_err_flag", err_flag, 0);
        chk("clr_tready",   s_axis_tready, 0);
        @(negedge ACLK);
        chk("clr_tready_back", s_axis_tready, 1);
        for (int k = 0; k < 4; k++) send_beat(32'd10 + 32'(k), (k == 3), st);
        end_session();
        check_stats("clr_after", 4, 1, 0, 0);

        // Asynchronous reset mid-packet, then a fresh session from a new seed.
        start_session(32'd5, 16'd4, 1'b0);
        send_beat(32'd5, 1'b0, st);
        send_beat(32'd6, 1'b0, st);
        chk("arst_pre_beat", beat_cnt, 2);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("arst_beat",   beat_cnt, 0);
        chk("arst_busy",   busy, 0);
        chk("arst_tready", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        cfg_enable    = 1'b0;
        @(negedge ACLK);
        ARESETN     = 1'b1;
        cfg_seed    = 32'd100;
        cfg_pkt_len = 16'd4;
        cfg_enable  = 1'b1;
        @(negedge ACLK);
        for (int k = 0; k < 4; k++) send_beat(32'd100 + 32'(k), (k == 3), st);
        end_session();
        check_stats("arst_after", 4, 1, 0, 0);

        // Throttled long stream with TVALID held high.
        rand_session("thr", $urandom, 4, 1000, 1'b1, 0, 0, st);
        chk("thr_beat_1000", beat_cnt, 1000);
        chk("thr_some_stalls", (st > 0), 1);

        for (int r = 0; r < 4; r++) begin
            rand_session($sformatf("rnd%0d", r), $urandom, $urandom_range(8), $urandom_range(80, 20),
                         1'($urandom_range(1)), 20, 10, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
